// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video-memory arbiter.
//
// Shares one synchronous-read block RAM between the VGA scan-out path and the
// maze generator. A display read owns the memory cycle that follows each
// pixel_tick during active video. Generator writes are queued in a small
// FIFO and drained into every memory cycle that is not a display read.
//
// Ports:
//   clk, reset        100 MHz clock, asynchronous active-high reset
//   pixel_tick        one-cycle 25 MHz pixel strobe
//   activevideo       current pixel is visible
//   rd_addr           cell address for the current pixel
//   rd_data/rd_valid  last fetched cell word / one-cycle update pulse
//   wr_req/addr/data  generator write, taken when wr_req && wr_ready
//   wr_ready          write FIFO has room
//   fifo_count        writes pending in the FIFO
//   mem_en/we/addr/wdata  registered memory command
//   mem_rdata         memory read data, valid one cycle after the command
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pixel_tick,
  input  logic                              activevideo,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid,
  input  logic                              wr_req,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  // Write FIFO storage and bookkeeping.
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // Memory command register.
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Read-return pipeline. tag_q[0] marks a read command on mem_*, tag_q[1]
  // marks the cycle its data is on mem_rdata.
  logic [1:0]        tag_q, tag_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic rd_slot;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  always_comb begin
    rd_slot    = pixel_tick && activevideo;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));

    // wr_ready looks only at full, so a full FIFO refuses a push even in a
    // cycle that also pops.
    wr_ready = !fifo_full && !reset;
    push     = wr_req && wr_ready;
    pop      = !rd_slot && !fifo_empty;

    // Depth is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Slot decision: display read always wins, then the FIFO head.
    // Idle cycles leave address and write data where they were.
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end else if (!fifo_empty) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end

    // Only tagged cycles carry read data, so writes never touch rd_data.
    tag_d      = {tag_q[0], rd_slot};
    rd_valid_d = tag_q[1];
    rd_data_d  = tag_q[1] ? mem_rdata : rd_data_q;
  end

  // FIFO payload needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign fifo_count = count_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk;
  logic          reset;
  logic          pixel_tick;
  logic          activevideo;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [2:0]    fifo_count;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int total;
  int bad;
  int cyc;
  logic [1:0]    phase;
  logic          tick_en;
  logic [DW-1:0] rd_expect;

  txn_t mf[$];       // writes sitting in the FIFO
  txn_t exp_wr[$];   // expected write commands on mem_*
  txn_t exp_cmd[$];  // expected read commands on mem_*
  txn_t exp_rd[$];   // expected rd_valid / rd_data updates

  logic [DW-1:0] ram [0:(1<<AW)-1];

  vram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_tick  (pixel_tick),
    .activevideo (activevideo),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .fifo_count  (fifo_count),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read block RAM behind the arbiter.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      else                 mem_rdata <= ram[mem_addr];
    end
  end

  // Advance one clock. Expectations are queued from the inputs sampled at the
  // edge; afterwards the new cycle's outputs are checked against the queues.
  task automatic step();
    txn_t t;
    logic rs, slot, do_push, do_pop;
    logic exp_ready;
    rs      = reset;
    slot    = !rs && pixel_tick && activevideo;
    do_push = !rs && wr_req && (mf.size() < DEPTH);
    do_pop  = !rs && !slot && (mf.size() > 0);
    if (rs) begin
      mf.delete();
      exp_wr.delete();
      exp_cmd.delete();
      exp_rd.delete();
    end
    if (slot) begin
      t.cyc = cyc + 1; t.addr = rd_addr; t.data = '0;
      exp_cmd.push_back(t);
      t.cyc = cyc + 3; t.data = rd_expect;
      exp_rd.push_back(t);
    end
    if (do_pop) begin
      t = mf.pop_front();
      t.cyc = cyc + 1;
      exp_wr.push_back(t);
    end
    if (do_push) begin
      t.cyc = cyc; t.addr = wr_addr; t.data = wr_data;
      mf.push_back(t);
    end

    @(posedge clk);
    #1;
    cyc++;

    total++;
    if (fifo_count !== 3'(mf.size())) begin
      bad++;
      $display("FAIL fifo_count cyc=%0d got=%0d want=%0d", cyc, fifo_count, mf.size());
    end
    exp_ready = !reset && (mf.size() < DEPTH);
    total++;
    if (wr_ready !== exp_ready) begin
      bad++;
      $display("FAIL wr_ready cyc=%0d got=%b want=%b", cyc, wr_ready, exp_ready);
    end

    if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
      t = exp_wr.pop_front();
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== t.addr || mem_wdata !== t.data) begin
        bad++;
        $display("FAIL mem_write cyc=%0d got en=%b we=%b a=%0d d=%h want a=%0d d=%h",
                 cyc, mem_en, mem_we, mem_addr, mem_wdata, t.addr, t.data);
      end
    end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
      total++; bad++;
      $display("FAIL mem_write_unexpected cyc=%0d got a=%0d d=%h want none",
               cyc, mem_addr, mem_wdata);
    end

    if (exp_cmd.size() > 0 && exp_cmd[0].cyc == cyc) begin
      t = exp_cmd.pop_front();
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== t.addr) begin
        bad++;
        $display("FAIL mem_read cyc=%0d got en=%b we=%b a=%0d want read a=%0d",
                 cyc, mem_en, mem_we, mem_addr, t.addr);
      end
    end else if (mem_en === 1'b1 && mem_we === 1'b0) begin
      total++; bad++;
      $display("FAIL mem_read_unexpected cyc=%0d got a=%0d want none", cyc, mem_addr);
    end

    if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
      t = exp_rd.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== t.data) begin
        bad++;
        $display("FAIL rd_return cyc=%0d got v=%b d=%h want v=1 d=%h",
                 cyc, rd_valid, rd_data, t.data);
      end
    end else if (rd_valid !== 1'b0) begin
      total++; bad++;
      $display("FAIL rd_valid_unexpected cyc=%0d got=%b want 0", cyc, rd_valid);
    end

    phase      = phase + 2'd1;
    pixel_tick = tick_en && (phase == 2'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (mf.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0) break;
      step();
    end
    total++;
    if (mf.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d/%0d/%0d want 0/0/0",
               name, mf.size(), exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_req = 1'b1; wr_addr = 11'd9; wr_data = 4'h5;
    activevideo = 1'b1; tick_en = 1'b1; rd_addr = 11'd3;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, rd_data, rd_valid, fifo_count, wr_ready} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got en=%b we=%b a=%0d d=%h rd=%h v=%b cnt=%0d rdy=%b want all 0",
                 cyc, mem_en, mem_we, mem_addr, mem_wdata, rd_data, rd_valid, fifo_count, wr_ready);
      end
    end
    reset = 1'b0; wr_req = 1'b0; activevideo = 1'b0;
    step();
  endtask

  task automatic test_blank_write();
    int e;
    activevideo = 1'b0; tick_en = 1'b1;
    wr_req = 1'b1; wr_addr = 11'd5; wr_data = 4'hA;
    e = cyc;
    step();
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL blank_write_early cyc=%0d got en=%b want 0", cyc, mem_en);
    end
    wr_addr = 11'd12; wr_data = 4'h3;   // preload the cell read later
    step();
    wr_req = 1'b0;
    total++;
    if (cyc != e + 2 || {mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 11'd5, 4'hA}) begin
      bad++;
      $display("FAIL blank_write cyc=%0d got en=%b we=%b a=%0d d=%h want 1 1 5 a",
               cyc, mem_en, mem_we, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_read();
    int n;
    activevideo = 1'b1; rd_addr = 11'd12; rd_expect = 4'h3; tick_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pixel_tick) break;
      step();
    end
    n = cyc;
    step();
    total++;
    if (cyc != n + 1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd12) begin
      bad++;
      $display("FAIL read_cmd cyc=%0d got en=%b we=%b a=%0d want 1 0 12", cyc, mem_en, mem_we, mem_addr);
    end
    step();
    step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 4'h3) begin
      bad++;
      $display("FAIL read_data cyc=%0d got v=%b d=%h want v=1 d=3", cyc, rd_valid, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 4'h3) begin
        bad++;
        $display("FAIL read_hold cyc=%0d got v=%b d=%h want v=0 d=3", cyc, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_fill();
    int k;
    activevideo = 1'b1; rd_addr = 11'd12; rd_expect = 4'h3;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      wr_req = 1'b1; wr_addr = 11'(100 + k); wr_data = 4'(k);
      k++;
      step();
      if (mf.size() == DEPTH) break;
    end
    total++;
    if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fill_full cyc=%0d got rdy=%b cnt=%0d want rdy=0 cnt=4", cyc, wr_ready, fifo_count);
    end
    // Full with a pop and a request: nothing is pushed.
    wr_addr = 11'(100 + k); wr_data = 4'(k);
    step();
    wr_req = 1'b0;
    total++;
    if (fifo_count !== 3'd3 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_no_push cyc=%0d got cnt=%0d rdy=%b want cnt=3 rdy=1",
               cyc, fifo_count, wr_ready);
    end
    drain("fill");
  endtask

  task automatic test_simul();
    activevideo = 1'b1; rd_addr = 11'd12; rd_expect = 4'h3;
    for (int i = 0; i < 20; i++) begin
      wr_req = 1'b1; wr_addr = 11'(300 + i); wr_data = 4'(i + 5);
      step();
      if (mf.size() == 2) break;
    end
    activevideo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_addr = 11'(400 + i); wr_data = 4'(9 + i);
      step();
      total++;
      if (fifo_count !== 3'd2) begin
        bad++;
        $display("FAIL push_pop_count cyc=%0d got=%0d want=2", cyc, fifo_count);
      end
    end
    wr_req = 1'b0;
    drain("simul");
  endtask

  task automatic test_reset_mid();
    activevideo = 1'b1; rd_addr = 11'd12; rd_expect = 4'h3; tick_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pixel_tick) break;
      step();
    end
    wr_req = 1'b1; wr_addr = 11'd200; wr_data = 4'h7;
    step();
    wr_addr = 11'd201; wr_data = 4'h8;
    step();
    reset = 1'b1; wr_req = 1'b0;
    step();
    total++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_read cyc=%0d got v=%b cnt=%0d want v=0 cnt=0", cyc, rd_valid, fifo_count);
    end
    reset = 1'b0; activevideo = 1'b0;
    step();
    total++;
    if (rd_data !== 4'h0 || rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_after cyc=%0d got d=%h v=%b cnt=%0d want 0 0 0",
               cyc, rd_data, rd_valid, fifo_count);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; phase = 2'd0; tick_en = 1'b0;
    reset = 1'b1; pixel_tick = 1'b0; activevideo = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_expect = '0;
    test_reset();
    test_blank_write();
    test_read();
    test_fill();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
